pack_send: RTL and testbench

PACK_SEND -- requirements
Module: pack_send

---
 rtl/pack_send_pkg.sv | 14 +
 rtl/pack_send_if.sv | 22 ++
 rtl/sync_ff.sv | 25 ++
 rtl/pack_send.sv | 148 ++++++++++++++
 tb/tb_pack_send.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pack_send_pkg.sv
// Shared types and constants for the pack_send sender and its downstream checkers.
package pack_send_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int TAIL_BIT = 1;
    localparam int HEAD_BIT = 0;

endpackage

// File: rtl/pack_send_if.sv
// Flit input handshake plus the two-phase bundled-data link toward the asynchronous side.
interface pack_send_if #(
    parameter int WORD_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-3:0] in_data;
    logic                  in_last;
    logic                  req;
    logic                  ack;
    logic [WORD_WIDTH-1:0] Data;

    modport master (
        input  in_valid, in_data, in_last, ack,
        output in_ready, req, Data
    );

    modport slave (
        output in_valid, in_data, in_last, ack,
        input  in_ready, req, Data
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with synchronous reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 occupies the low bits; the oldest sample sits at the top.
    logic [STAGES*WIDTH-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[(STAGES-1)*WIDTH-1:0], d};
        end
    end

    assign q = chain_reg[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/pack_send.sv
// Clocked flit source driving a two-phase bundled-data link with head/tail framing.
// Optional ack watchdog enabled by defining PACK_SEND_TIMEOUT_EN.
module pack_send
    import pack_send_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int SETUP_CYCLES   = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    pack_send_if.master bus,
    output logic [31:0] PacketTX,
    output logic        busy
`ifdef PACK_SEND_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    if (WORD_WIDTH < 3 || SYNC_STAGES < 2 || SETUP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pack_send: illegal parameter value");
    end

    state_t                state_reg, state_next;
    logic [WORD_WIDTH-1:0] data_reg, data_next;
    logic                  head_reg, head_next;
    logic                  req_reg, req_next;
    logic [31:0]           pkt_reg, pkt_next;
    logic [SETUP_W-1:0]    setup_cnt_reg, setup_cnt_next;
    logic                  ack_sync;
    logic                  in_ready;
    logic                  accept;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ack),
        .q     (ack_sync)
    );

    assign in_ready = (state_reg == IDLE) && !reset;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        head_next      = head_reg;
        req_next       = req_reg;
        pkt_next       = pkt_reg;
        setup_cnt_next = setup_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next      = {bus.in_data, bus.in_last, head_reg};
                    head_next      = bus.in_last;
                    setup_cnt_next = '0;
                    state_next     = (SETUP_CYCLES == 0) ? REQ : SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_reg == SETUP_W'(SETUP_CYCLES - 1)) begin
                    state_next = REQ;
                end else begin
                    setup_cnt_next = setup_cnt_reg + SETUP_W'(1);
                end
            end
            REQ: begin
                req_next   = ~req_reg;
                state_next = WAIT;
            end
            WAIT: begin
                // Stray ack edges outside WAIT never reach this comparison.
                if (ack_sync == req_reg) begin
                    if (data_reg[TAIL_BIT]) begin
                        pkt_next = pkt_reg + 32'd1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            head_reg      <= 1'b1;
            req_reg       <= 1'b0;
            pkt_reg       <= '0;
            setup_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            head_reg      <= head_next;
            req_reg       <= req_next;
            pkt_reg       <= pkt_next;
            setup_cnt_reg <= setup_cnt_next;
        end
    end

`ifdef PACK_SEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            to_err_reg, to_err_next;

    // The counter saturates at the limit; the FSM keeps waiting regardless.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        to_err_next = to_err_reg;
        if (state_reg == REQ) begin
            to_cnt_next = '0;
        end else if (state_reg == WAIT && to_cnt_reg != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
            if (to_cnt_next == TO_W'(TIMEOUT_CYCLES)) begin
                to_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg <= '0;
            to_err_reg <= 1'b0;
        end else begin
            to_cnt_reg <= to_cnt_next;
            to_err_reg <= to_err_next;
        end
    end

    assign timeout_err = to_err_reg;
`endif

    assign bus.in_ready = in_ready;
    assign bus.req      = req_reg;
    assign bus.Data     = data_reg;
    assign PacketTX     = pkt_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_pack_send.sv
// Directed bench for pack_send: flit table with ack loopback plus corner-case sequences.
module tb_pack_send;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    pack_send_if #(.WORD_WIDTH(32)) bus ();
    pack_send_if #(.WORD_WIDTH(32)) bus_s0 ();
    pack_send_if #(.WORD_WIDTH(32)) bus_s3 ();

    logic [31:0] pkts, pkts_s0, pkts_s3;
    logic        busy, busy_s0, busy_s3;
`ifdef PACK_SEND_TIMEOUT_EN
    logic        to_err, to_err_s0, to_err_s3;
`endif

    pack_send #(.WORD_WIDTH(32), .SETUP_CYCLES(1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .PacketTX(pkts), .busy(busy)
`ifdef PACK_SEND_TIMEOUT_EN
        , .timeout_err(to_err)
`endif
    );

    pack_send #(.WORD_WIDTH(32), .SETUP_CYCLES(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_s0 (
        .clk(clk), .reset(reset), .bus(bus_s0), .PacketTX(pkts_s0), .busy(busy_s0)
`ifdef PACK_SEND_TIMEOUT_EN
        , .timeout_err(to_err_s0)
`endif
    );

    pack_send #(.WORD_WIDTH(32), .SETUP_CYCLES(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_s3 (
        .clk(clk), .reset(reset), .bus(bus_s3), .PacketTX(pkts_s3), .busy(busy_s3)
`ifdef PACK_SEND_TIMEOUT_EN
        , .timeout_err(to_err_s3)
`endif
    );

    // Downstream model: ack echoes req three cycles later, or a manually held level.
    logic       loop_en;
    logic       ack_man;
    logic [2:0] dly;
    always @(posedge clk) begin
        if (reset) dly <= '0;
        else       dly <= {dly[1:0], bus.req};
    end
    assign bus.ack = loop_en ? dly[2] : ack_man;

    logic aux_valid;
    assign bus_s0.in_valid = aux_valid;
    assign bus_s0.in_data  = 30'h15;
    assign bus_s0.in_last  = 1'b1;
    assign bus_s0.ack      = bus_s0.req;
    assign bus_s3.in_valid = aux_valid;
    assign bus_s3.in_data  = 30'h15;
    assign bus_s3.in_last  = 1'b1;
    assign bus_s3.ack      = bus_s3.req;

    logic req_q = 1'b0;
    int   tog_cnt = 0;
    int   tog_edge = 0;
    always @(negedge clk) begin
        if (bus.req !== req_q) begin
            tog_cnt  <= tog_cnt + 1;
            tog_edge <= cyc;
        end
        req_q <= bus.req;
    end

    typedef struct {
        logic [29:0] d;
        logic        l;
        logic [1:0]  flags;
        logic [31:0] pkts;
    } vec_t;
    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [29:0] d, input logic l, output int acc);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", 64'(n < 50), 64'd1);
        step();
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        check({tag, "_done"}, 64'(n < 100), 64'd1);
    endtask

    task automatic run_flit(input string tag, input logic [29:0] d, input logic l,
                            input logic [1:0] flags, input logic [31:0] exp_pkts);
        int acc;
        int tog0;
        logic [31:0] word;
        tog0 = tog_cnt;
        word = {d, flags};
        send(d, l, acc);
        check({tag, "_data"}, 64'(bus.Data), 64'(word));
        wait_idle(tag);
        check({tag, "_hold"}, 64'(bus.Data), 64'(word));
        check({tag, "_toggles"}, 64'(tog_cnt - tog0), 64'd1);
        check({tag, "_req_edge"}, 64'(tog_edge - acc), 64'd2);
        check({tag, "_pkts"}, 64'(pkts), 64'(exp_pkts));
        $display("flit %s: payload=%h last=%b Data=%h PacketTX=%0h", tag, d, l, bus.Data, pkts);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t0, t3;
        logic req_before;

        vecs[0] = '{30'd5,          1'b0, 2'b01, 32'd0};
        vecs[1] = '{30'd6,          1'b0, 2'b00, 32'd0};
        vecs[2] = '{30'd7,          1'b1, 2'b10, 32'd1};
        vecs[3] = '{30'd9,          1'b1, 2'b11, 32'd2};
        vecs[4] = '{30'h3FFF_FFFF,  1'b0, 2'b01, 32'd2};
        vecs[5] = '{30'd0,          1'b1, 2'b10, 32'd3};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        loop_en      = 1'b1;
        ack_man      = 1'b0;
        aux_valid    = 1'b0;

        repeat (3) step();
        check("rst_req", 64'(bus.req), 64'd0);
        check("rst_data", 64'(bus.Data), 64'd0);
        check("rst_pkts", 64'(pkts), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef PACK_SEND_TIMEOUT_EN
        check("rst_timeout", 64'(to_err), 64'd0);
`endif
        reset = 1'b0;
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        step();

        for (int i = 0; i < 6; i++) begin
            run_flit($sformatf("vec%0d", i), vecs[i].d, vecs[i].l, vecs[i].flags, vecs[i].pkts);
        end

        // Stray ack toggles while idle must be ignored.
        req_before = bus.req;
        ack_man    = bus.ack;
        loop_en    = 1'b0;
        ack_man    = ~ack_man;
        repeat (6) step();
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_in_ready", 64'(bus.in_ready), 64'd1);
        check("spur_pkts", 64'(pkts), 64'd3);
        check("spur_req", 64'(bus.req), 64'(req_before));
        ack_man = ~ack_man;
        repeat (6) step();
        loop_en = 1'b1;
        run_flit("spur_next", 30'h2A, 1'b1, 2'b11, 32'd4);

        // Tail flit stuck in WAIT with a static ack, then abandoned by reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ack_man = 1'b0;
        loop_en = 1'b0;
        send(30'h12, 1'b1, acc);
        check("stuck_data", 64'(bus.Data), 64'({30'h12, 2'b11}));
        while (cyc < acc + 17) step();
        check("stuck_busy", 64'(busy), 64'd1);
`ifdef PACK_SEND_TIMEOUT_EN
        check("timeout_before", 64'(to_err), 64'd0);
`endif
        step();
        check("stuck_in_ready", 64'(bus.in_ready), 64'd0);
        check("stuck_req", 64'(bus.req), 64'd1);
`ifdef PACK_SEND_TIMEOUT_EN
        check("timeout_after", 64'(to_err), 64'd1);
`endif
        repeat (4) step();
        check("stuck_still_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        loop_en = 1'b1;
        check("abandon_req", 64'(bus.req), 64'd0);
        check("abandon_pkts", 64'(pkts), 64'd0);
        check("abandon_busy", 64'(busy), 64'd0);
`ifdef PACK_SEND_TIMEOUT_EN
        check("abandon_timeout", 64'(to_err), 64'd0);
`endif
        step();
        run_flit("after_rst", 30'h13, 1'b1, 2'b11, 32'd1);

        // SETUP_CYCLES=0 and =3 instances accept on the same edge.
        aux_valid = 1'b1;
        step();
        acc = cyc;
        aux_valid = 1'b0;
        t0 = -1;
        t3 = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (t0 < 0 && bus_s0.req === 1'b1) t0 = cyc;
            if (t3 < 0 && bus_s3.req === 1'b1) t3 = cyc;
        end
        check("setup0_req_edge", 64'(t0 - acc), 64'd1);
        check("setup3_req_edge", 64'(t3 - acc), 64'd4);
        $display("setup: accept edge %0d, req edges %0d and %0d", acc, t0, t3);
        repeat (10) step();
        check("setup0_pkts", 64'(pkts_s0), 64'd1);
        check("setup3_pkts", 64'(pkts_s3), 64'd1);

        // Counter wrap from a preloaded value.
        force dut.pkt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.pkt_reg;
        step();
        check("wrap_preload", 64'(pkts), 64'hFFFF_FFFE);
        run_flit("wrap_a", 30'h21, 1'b1, 2'b11, 32'hFFFF_FFFF);
        run_flit("wrap_b", 30'h22, 1'b1, 2'b11, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
